// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - register-file write-port arbiter between control FSM (port 0) and exception unit (port 1)
module regwrite_arbiter #(
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_data0,
   input  logic [DATA_W-1:0] req0_data1,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_data0,
   input  logic [DATA_W-1:0] req1_data1,
   output logic              req1_ready,
   output logic [2:0]        reg_dst,
   output logic              reg_write,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy,
   output logic              done,
   output logic              done_port
);

   typedef enum logic [1:0] {IDLE, WR1, WR2, ND} state_t;

   localparam logic [2:0] OP_WR_RT   = 3'b000;
   localparam logic [2:0] OP_WR_RD   = 3'b001;
   localparam logic [2:0] OP_LINK    = 3'b010;
   localparam logic [2:0] OP_POP     = 3'b011;
   localparam logic [2:0] OP_SP      = 3'b100;
   localparam logic [2:0] OP_WR_K    = 3'b101;
   localparam logic [2:0] OP_LINK_SP = 3'b110;
   localparam logic [2:0] OP_NOP     = 3'b111;

   localparam logic [2:0] DST_RT = 3'b000;
   localparam logic [2:0] DST_RD = 3'b001;
   localparam logic [2:0] DST_RA = 3'b010;
   localparam logic [2:0] DST_SP = 3'b011;
   localparam logic [2:0] DST_K  = 3'b100;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t            state;
   logic [2:0]        starve_cnt;
   logic              two_write_q;
   logic [DATA_W-1:0] data1_q;
   logic              port_q;

   logic              in_idle;
   logic              starved;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic [2:0]        sel_op;
   logic [DATA_W-1:0] sel_data0;
   logic [DATA_W-1:0] sel_data1;

   function automatic logic [2:0] first_dst(input logic [2:0] op);
      case (op)
         OP_WR_RT:   return DST_RT;
         OP_WR_RD:   return DST_RD;
         OP_LINK:    return DST_RA;
         OP_POP:     return DST_RT;
         OP_SP:      return DST_SP;
         OP_WR_K:    return DST_K;
         OP_LINK_SP: return DST_RA;
         default:    return DST_RT;
      endcase
   endfunction

   // Port 1 normally wins; port 0 is forced through once it has waited LIMIT grants.
   always_comb begin
      in_idle    = reset && (state == IDLE);
      starved    = req0_valid && (starve_cnt == LIMIT);
      grant1     = in_idle && req1_valid && !starved;
      grant0     = in_idle && req0_valid && !grant1;
      accept     = grant0 || grant1;
      sel_op     = grant1 ? req1_op    : req0_op;
      sel_data0  = grant1 ? req1_data0 : req0_data0;
      sel_data1  = grant1 ? req1_data1 : req0_data1;
      req0_ready = grant0;
      req1_ready = grant1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         reg_dst     <= DST_RT;
         reg_write   <= 1'b0;
         wb_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         done_port   <= 1'b0;
         starve_cnt  <= '0;
         two_write_q <= 1'b0;
         data1_q     <= '0;
         port_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               reg_write <= 1'b0;
               done      <= 1'b0;
               if (grant0 || !req0_valid)
                  starve_cnt <= '0;
               else if (grant1 && starve_cnt != LIMIT)
                  starve_cnt <= starve_cnt + 3'd1;
               if (accept) begin
                  two_write_q <= (sel_op == OP_POP) || (sel_op == OP_LINK_SP);
                  data1_q     <= sel_data1;
                  port_q      <= grant1;
                  busy        <= 1'b1;
                  if (sel_op == OP_NOP) begin
                     state     <= ND;
                     done      <= 1'b1;
                     done_port <= grant1;
                  end else begin
                     state     <= WR1;
                     reg_write <= 1'b1;
                     reg_dst   <= first_dst(sel_op);
                     wb_data   <= sel_data0;
                     if (!((sel_op == OP_POP) || (sel_op == OP_LINK_SP))) begin
                        done      <= 1'b1;
                        done_port <= grant1;
                     end
                  end
               end
            end
            WR1: begin
               if (two_write_q) begin
                  state     <= WR2;
                  reg_dst   <= DST_SP;
                  wb_data   <= data1_q;
                  done      <= 1'b1;
                  done_port <= port_q;
               end else begin
                  state     <= IDLE;
                  reg_write <= 1'b0;
                  done      <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               reg_write <= 1'b0;
               done      <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - randomized self-checking bench for regwrite_arbiter against a write-schedule model
module tb_regwrite_arbiter;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              req0_valid, req1_valid;
   logic [2:0]        req0_op, req1_op;
   logic [DATA_W-1:0] req0_data0, req0_data1, req1_data0, req1_data1;
   logic              req0_ready, req1_ready;
   logic [2:0]        reg_dst;
   logic              reg_write;
   logic [DATA_W-1:0] wb_data;
   logic              busy, done, done_port;

   regwrite_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_data0(req0_data0),
      .req0_data1(req0_data1), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_data0(req1_data0),
      .req1_data1(req1_data1), .req1_ready(req1_ready),
      .reg_dst(reg_dst), .reg_write(reg_write), .wb_data(wb_data),
      .busy(busy), .done(done), .done_port(done_port)
   );

   // one entry per future output cycle of a granted operation
   typedef struct {
      logic              we;
      logic [2:0]        dst;
      logic [DATA_W-1:0] data;
      logic              dn;
      logic              port;
   } act_t;

   act_t              sched[$];
   logic              m_busy, m_we, m_done, m_port;
   logic [2:0]        m_dst;
   logic [DATA_W-1:0] m_data;
   int                m_starve;
   int                last_grant;
   logic              obs_r0, obs_r1;
   int                grant_log[$];
   int                n_tests = 0;
   int                n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_op(input logic port, input logic [2:0] op,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
      logic [2:0] dst_tab [8];
      act_t a;
      dst_tab = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd2, 3'd0};
      a.port = port;
      if (op == 3'd7) begin
         a.we = 1'b0; a.dst = 3'd0; a.data = '0; a.dn = 1'b1;
         sched.push_back(a);
      end else if (op == 3'd3 || op == 3'd6) begin
         a.we = 1'b1; a.dst = dst_tab[op]; a.data = d0; a.dn = 1'b0;
         sched.push_back(a);
         a.dst = 3'd3; a.data = d1; a.dn = 1'b1;
         sched.push_back(a);
      end else begin
         a.we = 1'b1; a.dst = dst_tab[op]; a.data = d0; a.dn = 1'b1;
         sched.push_back(a);
      end
   endtask

   task automatic cycle();
      logic e0, e1;
      logic [2:0] op;
      logic [DATA_W-1:0] d0, d1;
      act_t a;
      @(negedge clk);
      #1;
      e1 = reset && !m_busy && req1_valid && !(req0_valid && m_starve == STARVE_LIMIT);
      e0 = reset && !m_busy && req0_valid && !e1;
      obs_r0 = req0_ready;
      obs_r1 = req1_ready;
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      last_grant = e1 ? 1 : (e0 ? 0 : -1);
      if (last_grant >= 0) grant_log.push_back(last_grant);
      op = e1 ? req1_op    : req0_op;
      d0 = e1 ? req1_data0 : req0_data0;
      d1 = e1 ? req1_data1 : req0_data1;
      @(posedge clk);
      if (!reset) begin
         sched.delete();
         m_busy = 0; m_we = 0; m_dst = 0; m_data = 0; m_done = 0; m_port = 0; m_starve = 0;
      end else begin
         if (!m_busy) begin
            if (e0 || !req0_valid) m_starve = 0;
            else if (e1 && m_starve < STARVE_LIMIT) m_starve++;
         end
         if (e0 || e1) push_op(e1, op, d0, d1);
         if (sched.size() > 0) begin
            a = sched.pop_front();
            m_busy = 1; m_we = a.we; m_done = a.dn;
            if (a.we) begin m_dst = a.dst; m_data = a.data; end
            if (a.dn) m_port = a.port;
         end else begin
            m_busy = 0; m_we = 0; m_done = 0;
         end
      end
      #1;
      chk("reg_write", reg_write, m_we);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("done_port", done_port, m_port);
      chk("reg_dst", reg_dst, m_dst);
      chk("wb_data", wb_data, m_data);
   endtask

   task automatic gen(output logic v, output logic [2:0] op,
                      output logic [DATA_W-1:0] d0, output logic [DATA_W-1:0] d1);
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      d0 = $urandom;
      d1 = $urandom;
   endtask

   initial begin
      int exp_seq [10];
      exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      m_busy = 0; m_we = 0; m_dst = 0; m_data = 0; m_done = 0; m_port = 0; m_starve = 0;
      last_grant = -1;

      // reset with both requesters valid
      reset = 1'b0;
      req0_valid = 1; req0_op = 3'd0; req0_data0 = 32'h5; req0_data1 = 32'h6;
      req1_valid = 1; req1_op = 3'd7; req1_data0 = 32'h7; req1_data1 = 32'h8;
      cycle();
      cycle();
      chk("rst_ready0", obs_r0, 0);
      chk("rst_ready1", obs_r1, 0);
      chk("rst_reg_write", reg_write, 0);
      reset = 1'b1;
      cycle();
      chk("rel_ready1", obs_r1, 1);
      req0_valid = 0; req1_valid = 0;
      cycle();

      // single write from port 0
      req0_valid = 1; req0_op = 3'd1; req0_data0 = 32'h0000_00AA;
      cycle();
      req0_valid = 0;
      chk("wr_rd_we", reg_write, 1);
      chk("wr_rd_dst", reg_dst, 3'b001);
      chk("wr_rd_data", wb_data, 32'hAA);
      chk("wr_rd_done", {done, done_port}, 2'b10);
      cycle();
      chk("wr_rd_t2_we", reg_write, 0);

      // two-write POP from port 1 while port 0 waits
      req1_valid = 1; req1_op = 3'd3; req1_data0 = 32'h11; req1_data1 = 32'h7FFF_EFFC;
      req0_valid = 1; req0_op = 3'd0; req0_data0 = 32'h22;
      cycle();
      chk("pop_t0_ready0", obs_r0, 0);
      req1_valid = 0;
      chk("pop_t1", {reg_dst, wb_data}, {3'b000, 32'h11});
      cycle();
      chk("pop_t1_ready0", obs_r0, 0);
      chk("pop_t2", {reg_dst, wb_data, done, done_port}, {3'b011, 32'h7FFF_EFFC, 2'b11});
      cycle();
      chk("pop_t2_ready0", obs_r0, 0);
      req0_valid = 0;
      cycle();

      // starvation pattern with both ports continuously valid
      grant_log.delete();
      req0_valid = 1; req0_op = 3'd0;
      req1_valid = 1; req1_op = 3'd1; req1_data0 = 32'h33;
      for (int i = 0; i < 20; i++) cycle();
      chk("starve_count", grant_log.size(), 10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++)
         chk($sformatf("starve_grant%0d", i), grant_log[i], exp_seq[i]);
      req0_valid = 0; req1_valid = 0;
      cycle();
      cycle();

      // reset in WR1 of LINK_SP aborts the burst
      req0_valid = 1; req0_op = 3'd6; req0_data0 = 32'h44; req0_data1 = 32'h55;
      cycle();
      req0_valid = 0; reset = 1'b0;
      cycle();
      chk("abort_state", {reg_write, reg_dst, done, busy}, 6'b0);
      reset = 1'b1;
      cycle();
      chk("abort_no_wr2", {reg_write, done}, 2'b00);

      // NOP, then withdrawal while busy
      req0_valid = 1; req0_op = 3'd7;
      cycle();
      req0_valid = 0;
      chk("nop_nd", {done, reg_write, busy}, 3'b101);
      cycle();
      req1_valid = 1; req1_op = 3'd3; req1_data0 = 32'h66; req1_data1 = 32'h77;
      cycle();
      req1_valid = 0; req0_valid = 1; req0_op = 3'd1; req0_data0 = 32'h88;
      cycle();
      req0_valid = 0;
      cycle();
      cycle();
      chk("withdraw_ready0", obs_r0, 0);
      chk("withdraw_no_write", reg_write, 0);

      // randomized traffic
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 800; i++) begin
         reset = ($urandom_range(0, 49) != 0);
         if (last_grant == 0 || (!req0_valid && $urandom_range(0, 1) == 1))
            gen(req0_valid, req0_op, req0_data0, req0_data1);
         else if (req0_valid && $urandom_range(0, 15) == 0)
            req0_valid = 0;
         if (last_grant == 1 || (!req1_valid && $urandom_range(0, 1) == 1))
            gen(req1_valid, req1_op, req1_data0, req1_data1);
         else if (req1_valid && $urandom_range(0, 15) == 0)
            req1_valid = 0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the single register-file write port between the main control FSM (port 0) and the exception unit (port 1).
- Grants one requester at a time and owns the write-port controls:
  - RegDst select (3-bit code consumed by the register-destination mux),
  - RegWrite,
  - the write-data word.
- Sequences multi-write operations (pop, link-with-stack) as atomic, non-preemptible bursts.
- Sits between the control unit / exception logic and the register bank, in front of the RegDst mux.

Parameters:
- DATA_W, 32, width of write-data words.
- STARVE_LIMIT, 4, consecutive port-1 grants allowed while port 0 waits; legal range 1..7.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous reset, active-low (state cleared on rising clk edge while reset=0)
- req0_valid  input  1  port 0 (control FSM) request
- req0_op  input  3  port 0 operation code
- req0_data0  input  DATA_W  port 0 first write word
- req0_data1  input  DATA_W  port 0 second write word (two-write ops only)
- req0_ready  output  1  port 0 request accepted this cycle
- req1_valid  input  1  port 1 (exception unit) request
- req1_op  input  3  port 1 operation code
- req1_data0  input  DATA_W  port 1 first write word
- req1_data1  input  DATA_W  port 1 second write word
- req1_ready  output  1  port 1 request accepted this cycle
- reg_dst  output  3  RegDst code: 000 rt, 001 rd, 010 $31, 011 $29, 100 $30
- reg_write  output  1  register-file write enable
- wb_data  output  DATA_W  register-file write data
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse on the last write of a burst
- done_port  output  1  port that owned the completed burst

Behaviour:
- Reset (reset=0 at clk edge), all registered:
  - reg_dst=000, reg_write=0, wb_data=0, busy=0, done=0, done_port=0;
  - starve counter=0; FSM goes to IDLE.
  - req*_ready are combinational and are 0 while reset=0.
- Reset mid-burst aborts the burst. No further reg_write is issued and no done pulse is produced.
- Op codes; writes are issued in the order listed:
  - 000 WR_RT: write rt <= data0.
  - 001 WR_RD: write rd <= data0.
  - 010 LINK: write $31 <= data0.
  - 011 POP: write rt <= data0, then $29 <= data1.
  - 100 SP: write $29 <= data0.
  - 101 WR_K: write $30 <= data0.
  - 110 LINK_SP: write $31 <= data0, then $29 <= data1.
  - 111 NOP: accepted; no write is issued.
- FSM states:
  - IDLE:
    - Arbitrates; req*_ready is asserted combinationally only in this state, for at most one port.
    - Port 1 wins when both ports are valid, unless starve counter == STARVE_LIMIT; in that case port 0 wins.
    - On valid&&ready the op, data0, data1 and port are captured. Next state is WR1, or ND for NOP.
  - WR1: reg_write=1; reg_dst and wb_data=data0 per op. Next state is WR2 for POP/LINK_SP, otherwise IDLE with done=1.
  - WR2: reg_write=1, reg_dst=011, wb_data=data1; done=1. Next state is IDLE.
  - ND: reg_write=0; done=1. Next state is IDLE.
- Output timing:
  - Outputs are registered and valid during the state named.
  - Latency for an acceptance at cycle T:
    - write (or ND) in cycle T+1;
    - second write in T+2;
    - next acceptance no earlier than the cycle after done.
  - Throughput is 1 request per 2 cycles for single-write ops.
- busy=1 in WR1, WR2 and ND; 0 in IDLE.
- Output values in IDLE:
  - reg_write=0;
  - reg_dst and wb_data hold their last values; they never change while reg_write=0 except on entering a write state.
- Port 1 is never granted mid-burst: a burst is atomic. Port 1 requests wait in IDLE with ready=0.
- Starve counter:
  - increments, saturating at STARVE_LIMIT, on each port-1 grant made while req0_valid=1;
  - clears on any port-0 grant, and whenever req0_valid=0 in IDLE.
- Requesters hold valid, op and data stable until ready. Deasserting valid before ready withdraws the request with no side effect.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 2 cycles with both valid=1 → all outputs 0, ready=0.
  - Release reset → req1_ready=1 in the first IDLE cycle.
- Single write: port 0 WR_RD with data0=0x0000_00AA →
  - T+1: reg_write=1, reg_dst=001, wb_data=0xAA, done=1, done_port=0;
  - T+2: reg_write=0.
- Two-write burst: port 1 POP with data0=0x11, data1=0x7FFF_EFFC →
  - T+1: reg_dst=000, wb_data=0x11;
  - T+2: reg_dst=011, wb_data=0x7FFF_EFFC, done=1, done_port=1;
  - port 0 (valid throughout) gets ready=0 during T..T+2.
- Priority and starvation: both ports valid continuously, STARVE_LIMIT=4 →
  - grants follow 1,1,1,1,0,1,1,1,1,0;
  - counter clears on each port-0 grant.
- Reset mid-burst: LINK_SP accepted, reset=0 in the WR1 cycle →
  - no WR2 write, no done pulse;
  - reg_write=0 and reg_dst=000 after the reset edge.
- NOP and withdrawal:
  - Port 0 op=111 → ND cycle with done=1 and reg_write=0.
  - Port 0 raises valid while busy and drops it before IDLE → no grant and no write.
